// File: rtl/hilo_mdu.sv
// Purpose: iterative MULT/MULTU/DIV/DIVU unit that owns the HI/LO register pair; also serves MFHI/MFLO/MTHI/MTLO.
// Latency: MULT/DIV busy for WIDTH+1 cycles, done pulses the cycle after HI/LO update; MT/MF complete in the issuing cycle.
// Backpressure: any start while busy raises stall and the command is dropped; the issuing stage re-presents it.
// Ports: clk/reset (sync, active-high); start+funct+src_a/src_b command; hilo = combinational MF read data;
//        busy = MULT/DIV in flight; stall = start & busy; done = one-cycle completion pulse.
module hilo_mdu #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic [WIDTH-1:0] hilo,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // Multiply: {partial product, remaining multiplier bits}. Divide: {remainder, quotient}.
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  // Multiplicand magnitude (multiply) or divisor magnitude (divide).
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic                 is_div_q, is_div_d;
  logic                 neg_q, neg_d;    // product / quotient must be negated in FIX
  logic                 rneg_q, rneg_d;  // remainder takes the dividend's sign
  logic                 dz_q, dz_d;      // divide by zero
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic                 op_signed, a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, div_sh, div_diff;
  logic [2*WIDTH-1:0]   prod_fix;
  logic [WIDTH-1:0]     quo, rem;

  assign busy  = (state_q != IDLE);
  assign stall = start & busy;
  assign done  = done_q;
  assign hilo  = (funct == F_MFHI) ? hi_q :
                 (funct == F_MFLO) ? lo_q : '0;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;

    // funct[0]=0 selects the signed variant, funct[1]=1 selects divide.
    op_signed = ~funct[0];
    a_neg     = op_signed & src_a[WIDTH-1];
    b_neg     = op_signed & src_b[WIDTH-1];
    a_mag     = a_neg ? -src_a : src_a;
    b_mag     = b_neg ? -src_b : src_b;

    // One shift-add step: add multiplicand into the upper half when the
    // current multiplier LSB is set, then shift the whole pair right.
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    // One restoring step: remainder shifted left with next dividend bit,
    // trial-subtract the divisor; MSB of the difference is the borrow.
    div_sh   = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, opnd_q};

    prod_fix = neg_q ? -acc_q : acc_q;
    quo      = acc_q[WIDTH-1:0];
    rem      = acc_q[2*WIDTH-1:WIDTH];

    case (state_q)
      IDLE: begin
        if (start) begin
          case (funct)
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              is_div_d = funct[1];
              neg_d    = a_neg ^ b_neg;
              rneg_d   = a_neg;
              dz_d     = (src_b == '0);
              if (funct[1]) begin
                acc_d  = {{WIDTH{1'b0}}, a_mag};
                opnd_d = b_mag;
              end else begin
                acc_d  = {{WIDTH{1'b0}}, b_mag};
                opnd_d = a_mag;
              end
              cnt_d   = CNT_W'(WIDTH - 1);
              state_d = RUN;
            end
            F_MTHI:  hi_d = src_a;
            F_MTLO:  lo_d = src_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (is_div_q) begin
          if (!div_diff[WIDTH])
            acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
          else
            acc_d = {div_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        if (cnt_q == '0)
          state_d = FIX;
        else
          cnt_d = cnt_q - CNT_W'(1);
      end
      FIX: begin
        if (is_div_q) begin
          // A zero divisor leaves the dividend magnitude as remainder, so the
          // sign restore returns src_a in HI; only LO needs forcing.
          lo_d = dz_q ? '1 : (neg_q ? -quo : quo);
          hi_d = rneg_q ? -rem : rem;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      dz_q     <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      dz_q     <= dz_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_hilo_mdu.sv
// Purpose: directed bench for hilo_mdu at WIDTH=32 and WIDTH=8 with hand-computed HI/LO results.
// Latency: checks WIDTH+1 busy cycles per MULT/DIV, done pulse timing, same-cycle MT/MF behaviour.
// Backpressure: checks stall during busy and that stalled commands are dropped.
module tb_hilo_mdu;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] src_a, src_b, hilo;
  logic        busy, stall, done;

  logic        start8;
  logic [5:0]  funct8;
  logic [7:0]  src_a8, src_b8, hilo8;
  logic        busy8, stall8, done8;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hilo_mdu #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .funct(funct),
    .src_a(src_a), .src_b(src_b), .hilo(hilo),
    .busy(busy), .stall(stall), .done(done)
  );

  hilo_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .funct(funct8),
    .src_a(src_a8), .src_b(src_b8), .hilo(hilo8),
    .busy(busy8), .stall(stall8), .done(done8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Presents a MULT/DIV in the current cycle (possibly the previous op's
  // done cycle), waits for completion, and reads HI/LO in the done cycle.
  task automatic run_op(input string tag, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    int early_done;
    start = 1'b1; funct = f; src_a = a; src_b = b;
    #1;
    check({tag, " idle_at_issue"}, busy, 0);
    tick();
    // Operands wander after accept; the result must not depend on them.
    start = 1'b0; funct = 6'h00; src_a = 32'hFFFF_FFFF; src_b = 32'h0000_0001;
    #1;
    check({tag, " done_low_after_accept"}, done, 0);
    n = 0;
    early_done = 0;
    while (busy && n < 100) begin
      if (done) early_done++;
      n++;
      tick();
    end
    check({tag, " busy_cycles"}, n, 33);
    check({tag, " early_done"}, early_done, 0);
    check({tag, " done_pulse"}, done, 1);
    start = 1'b1; funct = F_MFHI;
    #1;
    check({tag, " hi"}, hilo, exp_hi);
    funct = F_MFLO;
    #1;
    check({tag, " lo"}, hilo, exp_lo);
    start = 1'b0; funct = 6'h00;
  endtask

  initial begin
    int n;
    int dcount;

    reset = 1'b1; start = 1'b0; funct = 6'h00; src_a = '0; src_b = '0;
    start8 = 1'b0; funct8 = 6'h00; src_a8 = '0; src_b8 = '0;
    repeat (3) tick();

    // Reset state, with an MF read presented during reset.
    start = 1'b1; funct = F_MFHI;
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst stall", stall, 0);
    check("rst hi", hilo, 0);
    funct = F_MFLO;
    #1;
    check("rst lo", hilo, 0);
    check("rst busy8", busy8, 0);
    start = 1'b0; funct = 6'h00;
    tick();
    reset = 1'b0;
    tick();

    // Unlisted funct is ignored.
    start = 1'b1; funct = 6'h20; src_a = 32'h1234_5678; src_b = 32'h2;
    #1;
    check("bad_funct stall", stall, 0);
    tick();
    start = 1'b0;
    #1;
    check("bad_funct busy", busy, 0);

    // MTHI then MFHI next cycle; MTLO; hilo is 0 for non-MF functs.
    start = 1'b1; funct = F_MTHI; src_a = 32'hA5A5_A5A5;
    tick();
    check("mthi busy", busy, 0);
    funct = F_MTLO; src_a = 32'h5A5A_0F0F;
    #1;
    check("mtlo hilo_zero", hilo, 0);
    tick();
    funct = F_MFHI; src_a = 32'h0;
    #1;
    check("mfhi after mthi", hilo, 32'hA5A5_A5A5);
    funct = F_MFLO;
    #1;
    check("mflo after mtlo", hilo, 32'h5A5A_0F0F);
    check("mt busy", busy, 0);
    check("mt done", done, 0);
    start = 1'b0; funct = 6'h00;
    tick();

    // Arithmetic, issued back-to-back in each previous done cycle.
    run_op("mult_neg2x3",  F_MULT,  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op("multu_fffex3", F_MULTU, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0000_0002, 32'hFFFF_FFFA);
    run_op("div_m7d2",     F_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_7d2",     F_DIVU,  32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003);
    run_op("div_7dm2",     F_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf",      F_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_by0",     F_DIVU,  32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("div_m8_by0",   F_DIV,   32'hFFFF_FFF8, 32'h0000_0000, 32'hFFFF_FFF8, 32'hFFFF_FFFF);
    run_op("mult_big",     F_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    tick();

    // Stalled MTHI/MFLO during a MULTU: both are dropped while busy.
    start = 1'b1; funct = F_MTLO; src_a = 32'h0000_1234;
    tick();
    funct = F_MULTU; src_a = 32'h0000_0010; src_b = 32'h0000_0020;
    tick();
    start = 1'b0; funct = 6'h00;
    repeat (4) tick();
    start = 1'b1; funct = F_MTHI; src_a = 32'hDEAD_BEEF;
    #1;
    check("stall mthi", stall, 1);
    tick();
    funct = F_MFLO;
    n = 0;
    dcount = 0;
    while (busy && n < 100) begin
      if (!stall) dcount++;
      n++;
      tick();
    end
    check("stall held_every_cycle", dcount, 0);
    check("stall cycles", n, 28);
    check("stall released", stall, 0);
    check("stall mflo_new", hilo, 32'h0000_0200);
    funct = F_MFHI;
    #1;
    check("stall mthi_dropped", hilo, 32'h0000_0000);
    start = 1'b0; funct = 6'h00;
    tick();

    // Reset mid-DIV aborts: no result, no done.
    start = 1'b1; funct = F_DIV; src_a = 32'd100; src_b = 32'd7;
    tick();
    start = 1'b0; funct = 6'h00;
    repeat (10) tick();
    check("middiv busy_before", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("middiv busy", busy, 0);
    check("middiv done", done, 0);
    start = 1'b1; funct = F_MFHI;
    #1;
    check("middiv hi", hilo, 0);
    funct = F_MFLO;
    #1;
    check("middiv lo", hilo, 0);
    start = 1'b0; funct = 6'h00;
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) dcount++;
      tick();
    end
    check("middiv no_done", dcount, 0);

    // WIDTH=8 instance.
    start8 = 1'b1; funct8 = F_MULTU; src_a8 = 8'hFF; src_b8 = 8'hFF;
    tick();
    start8 = 1'b0; funct8 = 6'h00; src_a8 = 8'h00; src_b8 = 8'h00;
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      tick();
    end
    check("w8 busy_cycles", n, 9);
    check("w8 done", done8, 1);
    start8 = 1'b1; funct8 = F_MFHI;
    #1;
    check("w8 hi", hilo8, 8'hFE);
    funct8 = F_MFLO;
    #1;
    check("w8 lo", hilo8, 8'h01);
    funct8 = F_MULT; src_a8 = 8'hFE; src_b8 = 8'h03;
    tick();
    start8 = 1'b0; funct8 = 6'h00;
    n = 0;
    while (busy8 && n < 100) begin
      n++;
      tick();
    end
    check("w8 mult busy_cycles", n, 9);
    start8 = 1'b1; funct8 = F_MFHI;
    #1;
    check("w8 mult hi", hilo8, 8'hFF);
    funct8 = F_MFLO;
    #1;
    check("w8 mult lo", hilo8, 8'hFA);
    start8 = 1'b0; funct8 = 6'h00;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
